// File: rtl/regfile_pkg.sv
// Shared defaults and address-width helper for the multi-port integer register file.
package regfile_pkg;

   localparam int unsigned XLEN_DEF = 32'd32;
   localparam int unsigned NREG_DEF = 32'd32;
   localparam int unsigned ZERO_REG = '0;

   // Address width for a power-of-two register count; never below one bit.
   function automatic int unsigned regfile_aw(input int unsigned nreg);
      int unsigned w;
      w = 32'd1;
      for (int unsigned i = 32'd1; i < 32'd32; i++) begin
         if ((32'd1 << i) < nreg) begin
            w = i + 32'd1;
         end else begin
            w = w;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write-back scoreboard: busy bits, per-port hazard flags and sticky WAW error.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter  int unsigned NREG = NREG_DEF,
   parameter  int unsigned NRD  = 32'd2,
   localparam int unsigned AW   = regfile_aw(NREG)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NRD*AW-1:0] rd_addr,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic              alloc_en,
   input  logic [AW-1:0]     alloc_addr,
   output logic [NRD-1:0]    rd_busy,
   output logic [NREG-1:0]   busy_vec,
   output logic              waw_err
);

   logic [NREG-1:0] r_busy;
   logic            r_waw_err;
   logic [NREG-1:0] w_busy_nxt;
   logic            w_waw_hit;

   // Next busy state: alloc beats a same-cycle write because a newer producer was issued.
   always_comb begin
      w_busy_nxt = '0;
      for (int i = 0; i < int'(NREG); i++) begin
         if (i == 0) begin
            w_busy_nxt[i] = 1'b0;
         end else if (alloc_en && (alloc_addr == AW'(i))) begin
            w_busy_nxt[i] = 1'b1;
         end else if (wr_en && (wr_addr == AW'(i))) begin
            w_busy_nxt[i] = 1'b0;
         end else begin
            w_busy_nxt[i] = r_busy[i];
         end
      end
   end

   assign w_waw_hit = alloc_en && (alloc_addr != AW'(ZERO_REG)) && r_busy[alloc_addr]
                      && !(wr_en && (wr_addr == alloc_addr));

   // Scoreboard state and sticky WAW flag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_busy    <= '0;
         r_waw_err <= 1'b0;
      end else begin
         r_busy    <= w_busy_nxt;
         r_waw_err <= r_waw_err | w_waw_hit;
      end
   end

   for (genvar p = 0; p < int'(NRD); p++) begin : g_busy
      logic [AW-1:0] w_addr;
      assign w_addr     = rd_addr[p*AW +: AW];
      assign rd_busy[p] = r_busy[w_addr] && !(wr_en && (wr_addr == w_addr));
   end

   assign busy_vec = r_busy;
   assign waw_err  = r_waw_err;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with write-first bypass, hardwired x0 and RAW scoreboard.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter  int unsigned XLEN = XLEN_DEF,
   parameter  int unsigned NREG = NREG_DEF,
   parameter  int unsigned NRD  = 32'd2,
   localparam int unsigned AW   = regfile_aw(NREG)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [XLEN-1:0]     wr_data,
   input  logic                alloc_en,
   input  logic [AW-1:0]       alloc_addr,
   output logic [NREG-1:0]     busy_vec,
   output logic                waw_err
);

   logic [XLEN-1:0] r_regs [NREG];

   // Register storage; x0 is never written so it stays zero after reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < int'(NREG); i++) begin
            r_regs[i] <= '0;
         end
      end else if (wr_en && (wr_addr != AW'(ZERO_REG))) begin
         r_regs[wr_addr] <= wr_data;
      end else begin
         r_regs[0] <= '0;
      end
   end

   for (genvar p = 0; p < int'(NRD); p++) begin : g_rd
      logic [AW-1:0]   w_addr;
      logic [XLEN-1:0] w_data;
      assign w_addr = rd_addr[p*AW +: AW];

      // Write-first bypass so a consumer sees the value being written back this cycle.
      always_comb begin
         if (w_addr == AW'(ZERO_REG)) begin
            w_data = '0;
         end else if (wr_en && (wr_addr == w_addr)) begin
            w_data = wr_data;
         end else begin
            w_data = r_regs[w_addr];
         end
      end

      assign rd_data[p*XLEN +: XLEN] = w_data;
   end

   regfile_scoreboard #(
      .NREG (NREG),
      .NRD  (NRD)
   ) u_scoreboard (
      .clk        (clk),
      .reset      (reset),
      .rd_addr    (rd_addr),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .alloc_en   (alloc_en),
      .alloc_addr (alloc_addr),
      .rd_busy    (rd_busy),
      .busy_vec   (busy_vec),
      .waw_err    (waw_err)
   );

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized self-checking bench for regfile_mp: default config plus a 64-bit/16-reg/3-port copy.
module tb_regfile_mp;

   localparam int AXL = 32, ANR = 32, ANRD = 2, AAW = 5;
   localparam int BXL = 64, BNR = 16, BNRD = 3, BAW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                  a_reset, a_wr_en, a_alloc_en, a_waw_err;
   logic [ANRD*AAW-1:0]   a_rd_addr;
   logic [ANRD*AXL-1:0]   a_rd_data;
   logic [ANRD-1:0]       a_rd_busy;
   logic [AAW-1:0]        a_wr_addr, a_alloc_addr;
   logic [AXL-1:0]        a_wr_data;
   logic [ANR-1:0]        a_busy_vec;

   logic                  b_reset, b_wr_en, b_alloc_en, b_waw_err;
   logic [BNRD*BAW-1:0]   b_rd_addr;
   logic [BNRD*BXL-1:0]   b_rd_data;
   logic [BNRD-1:0]       b_rd_busy;
   logic [BAW-1:0]        b_wr_addr, b_alloc_addr;
   logic [BXL-1:0]        b_wr_data;
   logic [BNR-1:0]        b_busy_vec;

   int n_cmp = 0;
   int n_err = 0;

   // reference state
   logic [AXL-1:0] ma_reg [ANR];
   logic [ANR-1:0] ma_busy;
   logic           ma_err;
   logic [BXL-1:0] mb_reg [BNR];
   logic [BNR-1:0] mb_busy;
   logic           mb_err;

   regfile_mp dut_a (
      .clk(clk), .reset(a_reset), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
      .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .alloc_en(a_alloc_en),
      .alloc_addr(a_alloc_addr), .busy_vec(a_busy_vec), .waw_err(a_waw_err)
   );

   regfile_mp #(.XLEN(BXL), .NREG(BNR), .NRD(BNRD)) dut_b (
      .clk(clk), .reset(b_reset), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
      .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .alloc_en(b_alloc_en),
      .alloc_addr(b_alloc_addr), .busy_vec(b_busy_vec), .waw_err(b_waw_err)
   );

   function automatic logic [AXL-1:0] exp_rd_a(input logic [AAW-1:0] ad);
      if (ad == 0) return '0;
      if (a_wr_en && a_wr_addr == ad) return a_wr_data;
      return ma_reg[ad];
   endfunction

   function automatic logic exp_rb_a(input logic [AAW-1:0] ad);
      return ma_busy[ad] && !(a_wr_en && a_wr_addr == ad);
   endfunction

   function automatic logic [BXL-1:0] exp_rd_b(input logic [BAW-1:0] ad);
      if (ad == 0) return '0;
      if (b_wr_en && b_wr_addr == ad) return b_wr_data;
      return mb_reg[ad];
   endfunction

   // Advance one clock edge and apply the architectural rules to both reference models.
   task automatic tick();
      @(posedge clk);
      if (!a_reset) begin
         for (int i = 0; i < ANR; i++) ma_reg[i] = '0;
         ma_busy = '0;
         ma_err  = 1'b0;
      end else begin
         if (a_alloc_en && a_alloc_addr != 0 && ma_busy[a_alloc_addr] &&
             !(a_wr_en && a_wr_addr == a_alloc_addr)) ma_err = 1'b1;
         if (a_wr_en && a_wr_addr != 0) begin
            ma_reg[a_wr_addr]  = a_wr_data;
            ma_busy[a_wr_addr] = 1'b0;
         end
         if (a_alloc_en && a_alloc_addr != 0) ma_busy[a_alloc_addr] = 1'b1;
      end
      if (!b_reset) begin
         for (int i = 0; i < BNR; i++) mb_reg[i] = '0;
         mb_busy = '0;
         mb_err  = 1'b0;
      end else begin
         if (b_alloc_en && b_alloc_addr != 0 && mb_busy[b_alloc_addr] &&
             !(b_wr_en && b_wr_addr == b_alloc_addr)) mb_err = 1'b1;
         if (b_wr_en && b_wr_addr != 0) begin
            mb_reg[b_wr_addr]  = b_wr_data;
            mb_busy[b_wr_addr] = 1'b0;
         end
         if (b_alloc_en && b_alloc_addr != 0) mb_busy[b_alloc_addr] = 1'b1;
      end
      #1;
   endtask

   task automatic idle_inputs();
      a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_alloc_en = 1'b0; a_alloc_addr = '0;
      b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_alloc_en = 1'b0; b_alloc_addr = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      a_reset = 1'b0; b_reset = 1'b0;
      tick();
      a_reset = 1'b1; b_reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'hDEADBEEF;
      a_alloc_en = 1'b1; a_alloc_addr = 5'd6;
      tick();
      // reset overrides a concurrent write and alloc
      a_reset = 1'b0; a_wr_addr = 5'd8; a_alloc_addr = 5'd6;
      tick();
      a_reset = 1'b1; idle_inputs();
      for (int ad = 0; ad < ANR; ad++) begin
         a_rd_addr = {AAW'(ad), AAW'(ad)};
         #1;
         n_cmp++;
         if (a_rd_data !== '0) begin
            n_err++;
            $display("FAIL reset_rd addr=%0d got %h want 0", ad, a_rd_data);
         end
      end
      n_cmp++;
      if (a_busy_vec !== '0 || a_rd_busy !== '0) begin
         n_err++;
         $display("FAIL reset_busy got busy_vec=%h rd_busy=%b want 0", a_busy_vec, a_rd_busy);
      end
      n_cmp++;
      if (a_waw_err !== 1'b0) begin
         n_err++;
         $display("FAIL reset_waw got %b want 0", a_waw_err);
      end
   endtask

   task automatic test_x0();
      a_rd_addr = '0;
      a_wr_en = 1'b1; a_wr_addr = '0; a_wr_data = 32'hFFFFFFFF;
      #1;
      n_cmp++;
      if (a_rd_data !== '0) begin
         n_err++;
         $display("FAIL x0_same got %h want 0", a_rd_data);
      end
      tick();
      a_wr_en = 1'b0;
      #1;
      n_cmp++;
      if (a_rd_data !== '0) begin
         n_err++;
         $display("FAIL x0_next got %h want 0", a_rd_data);
      end
   endtask

   task automatic test_bypass();
      a_rd_addr = {5'd7, 5'd7};
      a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'h12345678;
      #1;
      n_cmp++;
      if (a_rd_data !== {32'h12345678, 32'h12345678}) begin
         n_err++;
         $display("FAIL bypass_same got %h want 1234567812345678", a_rd_data);
      end
      tick();
      a_wr_en = 1'b0; a_wr_data = 32'h0BADF00D;
      #1;
      n_cmp++;
      if (a_rd_data !== {32'h12345678, 32'h12345678}) begin
         n_err++;
         $display("FAIL bypass_held got %h want 1234567812345678", a_rd_data);
      end
   endtask

   task automatic test_scoreboard();
      do_reset();
      a_alloc_en = 1'b1; a_alloc_addr = 5'd3;
      tick();
      a_alloc_en = 1'b0;
      a_rd_addr = {5'd3, 5'd3};
      #1;
      n_cmp++;
      if (a_busy_vec !== 32'h0000_0008) begin
         n_err++;
         $display("FAIL sb_alloc busy_vec got %h want 00000008", a_busy_vec);
      end
      n_cmp++;
      if (a_rd_busy !== 2'b11) begin
         n_err++;
         $display("FAIL sb_rd_busy got %b want 11", a_rd_busy);
      end
      a_wr_en = 1'b1; a_wr_addr = 5'd3; a_wr_data = 32'h0000_00A5;
      #1;
      n_cmp++;
      if (a_rd_busy !== 2'b00 || a_rd_data !== {32'hA5, 32'hA5}) begin
         n_err++;
         $display("FAIL sb_wb_bypass got rd_busy=%b data=%h want 00 / a5", a_rd_busy, a_rd_data);
      end
      tick();
      a_wr_en = 1'b0;
      #1;
      n_cmp++;
      if (a_busy_vec !== '0 || a_rd_data !== {32'hA5, 32'hA5}) begin
         n_err++;
         $display("FAIL sb_cleared got busy_vec=%h data=%h", a_busy_vec, a_rd_data);
      end
   endtask

   task automatic test_alloc_wr_same();
      do_reset();
      a_alloc_en = 1'b1; a_alloc_addr = 5'd9;
      tick();
      a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'hCAFE_0009;
      tick();
      idle_inputs();
      a_rd_addr = {5'd0, 5'd9};
      #1;
      n_cmp++;
      if (a_waw_err !== 1'b0 || a_busy_vec[9] !== 1'b1) begin
         n_err++;
         $display("FAIL alloc_wr_same got waw=%b busy9=%b want 0/1", a_waw_err, a_busy_vec[9]);
      end
      n_cmp++;
      if (a_rd_data[AXL-1:0] !== 32'hCAFE_0009) begin
         n_err++;
         $display("FAIL alloc_wr_data got %h want cafe0009", a_rd_data[AXL-1:0]);
      end
   endtask

   task automatic test_waw();
      do_reset();
      a_alloc_en = 1'b1; a_alloc_addr = 5'd4;
      tick();
      #1;
      n_cmp++;
      if (a_waw_err !== 1'b0) begin
         n_err++;
         $display("FAIL waw_first got %b want 0", a_waw_err);
      end
      tick();
      a_alloc_en = 1'b0;
      for (int c = 0; c < 3; c++) begin
         a_wr_en = 1'b1; a_wr_addr = 5'd4; a_wr_data = $urandom;
         #1;
         n_cmp++;
         if (a_waw_err !== 1'b1) begin
            n_err++;
            $display("FAIL waw_sticky cyc=%0d got %b want 1", c, a_waw_err);
         end
         tick();
      end
      do_reset();
      #1;
      n_cmp++;
      if (a_waw_err !== 1'b0) begin
         n_err++;
         $display("FAIL waw_reset got %b want 0", a_waw_err);
      end
   endtask

   task automatic test_waw_wide();
      do_reset();
      b_alloc_en = 1'b1; b_alloc_addr = 4'd4;
      tick();
      tick();
      b_alloc_en = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_cmp++;
         if (b_waw_err !== 1'b1 || b_busy_vec !== 16'h0010) begin
            n_err++;
            $display("FAIL waw_wide cyc=%0d got waw=%b busy=%h want 1/0010", c, b_waw_err, b_busy_vec);
         end
         tick();
      end
   endtask

   task automatic test_random_a();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         a_reset      = ($urandom_range(0, 39) != 0);
         a_rd_addr    = $urandom;
         a_wr_en      = $urandom_range(0, 1);
         a_wr_addr    = $urandom;
         a_wr_data    = $urandom;
         a_alloc_en   = ($urandom_range(0, 3) == 0);
         a_alloc_addr = $urandom;
         if ($urandom_range(0, 3) == 0) a_rd_addr[AAW-1:0] = a_wr_addr;
         #1;
         for (int p = 0; p < ANRD; p++) begin
            n_cmp++;
            if (a_rd_data[p*AXL +: AXL] !== exp_rd_a(a_rd_addr[p*AAW +: AAW]) ||
                a_rd_busy[p] !== exp_rb_a(a_rd_addr[p*AAW +: AAW])) begin
               n_err++;
               $display("FAIL rand_a_rd cyc=%0d p=%0d got %h/%b want %h/%b", c, p,
                        a_rd_data[p*AXL +: AXL], a_rd_busy[p],
                        exp_rd_a(a_rd_addr[p*AAW +: AAW]), exp_rb_a(a_rd_addr[p*AAW +: AAW]));
            end
         end
         n_cmp++;
         if (a_busy_vec !== ma_busy || a_waw_err !== ma_err) begin
            n_err++;
            $display("FAIL rand_a_sb cyc=%0d got %h/%b want %h/%b", c, a_busy_vec, a_waw_err,
                     ma_busy, ma_err);
         end
         tick();
      end
      a_reset = 1'b1;
   endtask

   task automatic test_random_b();
      do_reset();
      for (int c = 0; c < 300; c++) begin
         b_reset      = ($urandom_range(0, 49) != 0);
         b_rd_addr    = $urandom;
         b_wr_en      = $urandom_range(0, 1);
         b_wr_addr    = $urandom;
         b_wr_data    = {$urandom, $urandom};
         b_alloc_en   = ($urandom_range(0, 4) == 0);
         b_alloc_addr = $urandom;
         #1;
         for (int p = 0; p < BNRD; p++) begin
            n_cmp++;
            if (b_rd_data[p*BXL +: BXL] !== exp_rd_b(b_rd_addr[p*BAW +: BAW])) begin
               n_err++;
               $display("FAIL rand_b_rd cyc=%0d p=%0d got %h want %h", c, p,
                        b_rd_data[p*BXL +: BXL], exp_rd_b(b_rd_addr[p*BAW +: BAW]));
            end
         end
         n_cmp++;
         if (b_busy_vec !== mb_busy || b_waw_err !== mb_err) begin
            n_err++;
            $display("FAIL rand_b_sb cyc=%0d got %h/%b want %h/%b", c, b_busy_vec, b_waw_err,
                     mb_busy, mb_err);
         end
         tick();
      end
      b_reset = 1'b1;
   endtask

   initial begin
      a_rd_addr = '0; b_rd_addr = '0;
      idle_inputs();
      a_reset = 1'b0; b_reset = 1'b0;
      tick();
      test_reset();
      test_x0();
      test_bypass();
      test_scoreboard();
      test_alloc_wr_same();
      test_waw();
      test_waw_wide();
      test_random_a();
      test_random_b();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port integer register file for the RV32 single-cycle core and its planned pipelined successor. It has NRD combinational read ports and one synchronous write port. The write port bypasses to the reads in the same cycle. Register 0 is hardwired to zero. A built-in scoreboard tracks registers with a pending write-back, so issue logic can detect RAW hazards.

## Interface
- XLEN, 32, data width in bits (≥8)
- NREG, 32, number of architectural registers; power of two, ≥2
- NRD, 2, number of read ports (1..4)
- AW, $clog2(NREG), derived localparam, not overridable
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset, sampled on rising clk edge
- rd_addr  in  NRD*AW  read addresses; port p at [p*AW +: AW]
- rd_data  out  NRD*XLEN  read data; port p at [p*XLEN +: XLEN]
- rd_busy  out  NRD  port p's register has a pending write not satisfied this cycle
- wr_en  in  1  write-back strobe
- wr_addr  in  AW  write-back address
- wr_data  in  XLEN  write-back data
- alloc_en  in  1  issue stage marks alloc_addr as pending a write-back
- alloc_addr  in  AW  register being allocated
- busy_vec  out  NREG  scoreboard state, bit i = register i pending
- waw_err  out  1  sticky: alloc_en hit an already-busy register

## Operation
- Storage: NREG × XLEN array, busy[NREG], err flag.
- Reset (reset==0 at edge): all registers are 0, busy is all-0, and waw_err is 0. Reset overrides wr_en and alloc_en in the same cycle.
- Write: at an edge with reset==1, wr_en==1 and wr_addr≠0, reg[wr_addr] ← wr_data. A write to address 0 is discarded.
- Read port p (combinational):
  - rd_addr==0 → 0.
  - Else wr_en && wr_addr==rd_addr → wr_data (write-first bypass).
  - Else → reg[rd_addr].
- Scoreboard update at edge (reset==1), for each register i≠0:
  - Set if alloc_en && alloc_addr==i.
  - Else clear if wr_en && wr_addr==i.
  - Else hold.
  - Same-cycle alloc and write to the same register: the alloc wins and the bit stays 1, because a new producer has been issued.
- busy[0] is constant 0. alloc or write to 0 has no effect.
- rd_busy[p] = busy[rd_addr[p]] && !(wr_en && wr_addr==rd_addr[p]), i.e. the bypass resolves the hazard.
- WAW detection: alloc_en && alloc_addr≠0 && busy[alloc_addr] && !(wr_en && wr_addr==alloc_addr) sets waw_err at the edge. waw_err holds until reset.
- A write-back to a non-busy register is legal: data is written and busy stays 0.

## Timing
- Read latency: 0 cycles, purely combinational from rd_addr, wr_en, wr_addr and wr_data.
- Write visible through storage from the cycle after the edge. Visible through bypass in the same cycle.
- busy_vec, waw_err: registered, updated at the edge, so visible the cycle after alloc or write.
- rd_busy: combinational from registered busy and current write port.
- All outputs after reset: rd_data=0 for every address, rd_busy=0, busy_vec=0, waw_err=0.
- A reset asserted mid-operation discards the pending write and alloc in that cycle. There are no partial updates.

## Structure
- Package regfile_pkg holds:
  - defaults XLEN_DEF=32, NREG_DEF=32;
  - ZERO_REG='0;
  - localparam function for AW.
- Sub-module regfile_scoreboard (busy bits, rd_busy generation, waw_err) is instantiated once in regfile_mp.
- Storage and bypass muxes stay in regfile_mp. Read ports are generated with a generate loop over NRD.

## Test plan
- Reset: write x5=0xDEADBEEF, then hold reset low for 1 edge → all rd_data=0, busy_vec=0, waw_err=0.
- x0 immutable: wr_en, wr_addr=0, wr_data=0xFFFFFFFF → rd_data for addr 0 is 0 in the same cycle and the next cycle.
- Bypass:
  - Same cycle: wr x7=0x12345678 with rd_addr port0=7, port1=7 → both read 0x12345678 before the edge.
  - After the edge: value held with wr_en=0.
- Scoreboard:
  - alloc x3 → busy_vec[3]=1 next cycle.
  - rd_addr=3 → rd_busy=1.
  - Same cycle as wr x3=0xA5 → rd_busy=0, rd_data=0xA5.
  - Next cycle → busy_vec[3]=0.
- Simultaneous alloc and wr on x9 (x9 busy): no waw_err, busy_vec[9] stays 1, reg x9 updated.
- WAW: alloc x4 twice with no intervening write → waw_err=1 from the cycle after the second alloc, sticky until reset. Repeat with NREG=16, NRD=3, XLEN=64.
